calc_sequencer: RTL and testbench
=================================

Name: calc_sequencer

Overview:
Parametrised successor of the calculator controller. It accepts a stream of button events through a valid/ready handshake and assembles multi-digit BCD operands of DIGITS digits. It chains operators, repeats the last operation on successive '=', and drives a multi-cycle ALU through a request/done handshake. It owns the display and upper (accumulator) registers internally and latches ALU errors until cleared.

Parameters:
DIGITS, 8, significand digit count; legal range 2..16
EXP_W, $clog2(DIGITS), exponent field width of num_t

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset; one clock; reset is asynchronous and active-low
button_valid_i  in  1  button event present
button_i  in  active_button_t  button code
button_ready_o  out  1  sequencer can accept an event
alu_valid_o  out  1  ALU request
alu_ready_i  in  1  ALU accepts request
alu_left_o  out  num_t  left operand
alu_right_o  out  num_t  right operand
alu_op_o  out  op_t  operation
alu_done_i  in  1  result valid, single-cycle pulse
alu_result_i  in  num_t  result
alu_err_i  in  1  overflow/div-by-zero, qualified by alu_done_i
display_o  out  num_t  display register
upper_o  out  num_t  accumulator register
error_o  out  1  sticky error

Behaviour:
- num_t = {sign, exp[EXP_W-1:0], significand[DIGITS-1:0][3:0] BCD}. Value = d[DIGITS-1].d[DIGITS-2]... × 10^exp. Zero = all fields 0.
- Reset (async, rst_ni=0): state IDLE; display_o=upper_o=0; pending_op=NONE; repeat_valid=0; entry_active=0; error_o=0; alu_valid_o=0; button_ready_o=1; ALU operand/op outputs=0.
- An event is accepted when button_valid_i && button_ready_o. B_NONE is accepted with no effect.
- States:
  - IDLE: ready=1.
  - ALU_REQ: alu_valid_o=1; ready=0.
  - ALU_WAIT: ready=0.
  - ERROR: ready=1; only B_CLEAR has effect.
- Digit n:
  - If entry_active=0, display becomes n placed at d[DIGITS-1], exp=0, sign=0, and entry_active is set.
  - Otherwise n is written to the next lower digit and exp increments.
  - When DIGITS digits are already entered, the digit is ignored.
  - A leading 0 while display is zero does not advance the position.
  - Display updates on the cycle after acceptance.
- B_OP_x (ADD/SUB/MUL/DIV):
  - If pending_op≠NONE and entry_active=1: issue ALU(upper, pending_op, display).
  - Otherwise: upper←display, no ALU request.
  - In both cases pending_op←x and entry_active←0.
- B_OP_EQ:
  - pending_op≠NONE: issue ALU(upper, pending_op, display). Set last_op←pending_op, last_operand←display, repeat_valid←1, pending_op←NONE. A right operand equal to display when no new entry is made is intended behaviour (1 + = → 2).
  - pending_op=NONE and repeat_valid: issue ALU(display, last_op, last_operand).
  - Otherwise: no effect.
  - entry_active←0 in all cases.
- B_CLEAR_ENTRY: display←0, entry_active←0; pending op retained.
- B_CLEAR: full reset state (synchronous equivalent), from any non-ALU state.
- B_NEG: toggles display sign; zero stays positive.
- ALU issue:
  - Next cycle the sequencer enters ALU_REQ with operands and op held stable.
  - On alu_valid_o && alu_ready_i it moves to ALU_WAIT.
  - alu_done_i is accepted in ALU_REQ (same cycle as handshake) or in ALU_WAIT, and ignored elsewhere.
- ALU done:
  - Without error: display←result; upper←result for operator chaining; EQ leaves upper←result; return to IDLE. ready=1 on the cycle after done.
  - With alu_err_i: error_o←1, display←0, go to ERROR.
- Reset mid-operation: aborts the request immediately; alu_valid_o drops asynchronously.
- Minimum latency: digit = 1 cycle; ALU op = 3 cycles (accept → REQ → done → IDLE).

Decomposition:
- calc_pkg gains:
  - active_button_t: B_NONE, B_NUM_0..9, B_OP_ADD/SUB/MUL/DIV/EQ, B_CLEAR, B_CLEAR_ENTRY, B_NEG
  - op_t: OP_NONE, OP_ADD, OP_SUB, OP_MUL, OP_DIV
  - parametrised num_t
  - state enum
  - function is_digit()
- One sub-module, calc_entry: the digit-append/negate/clear datapath on num_t, parametrised by DIGITS.

Test Plan:
- DIGITS=8. Press 1,2,3 → display d7..d5=1,2,3, exp=2; ninth digit of 9 keys ignored, exp stays 7.
- 1 + 2 = with ALU done 2 cycles after request → alu_left=1, alu_right=2, op=ADD; display=3, upper=3. button_ready_o low for exactly 3 cycles.
- 1 + 2 = = = (ALU stub adds) → displays 3, 5, 7. Each repeat request has left=display, right=2.
- 2 × 3 + 4 = → first ALU request issued at '+' gives display 6; final display 10.
- 5 ÷ 0 = with stub asserting alu_err_i → error_o=1, display=0. Digit 7 is ignored. B_CLEAR → error_o=0, display=0.
- rst_ni low while in ALU_WAIT → alu_valid_o=0 and all registers 0 immediately. A late alu_done_i after release is ignored.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared types for the calculator sequencer: button codes, ALU ops, FSM states,
// the default-width operand type and button decode helpers.
package calc_pkg;

    localparam int DEF_DIGITS = 8;
    localparam int DEF_EXP_W  = $clog2(DEF_DIGITS);

    typedef enum logic [4:0] {
        B_NONE,
        B_NUM_0, B_NUM_1, B_NUM_2, B_NUM_3, B_NUM_4,
        B_NUM_5, B_NUM_6, B_NUM_7, B_NUM_8, B_NUM_9,
        B_OP_ADD, B_OP_SUB, B_OP_MUL, B_OP_DIV, B_OP_EQ,
        B_CLEAR, B_CLEAR_ENTRY, B_NEG
    } active_button_t;

    typedef enum logic [2:0] {
        OP_NONE, OP_ADD, OP_SUB, OP_MUL, OP_DIV
    } op_t;

    typedef enum logic [1:0] {
        S_IDLE, S_ALU_REQ, S_ALU_WAIT, S_ERROR
    } state_t;

    typedef enum logic [1:0] {
        E_HOLD, E_DIGIT, E_NEG, E_CLEAR
    } entry_op_t;

    // Operand layout for the default digit count; modules build the same
    // layout from their own DIGITS parameter.
    typedef struct packed {
        logic                       sign;
        logic [DEF_EXP_W-1:0]       exp;
        logic [DEF_DIGITS-1:0][3:0] sig;
    } num_t;

    function automatic logic is_digit(input active_button_t b);
        return (b >= B_NUM_0) && (b <= B_NUM_9);
    endfunction

    function automatic logic [3:0] digit_of(input active_button_t b);
        logic [4:0] d;
        d = 5'(b) - 5'(B_NUM_0);
        return d[3:0];
    endfunction

    function automatic logic is_operator(input active_button_t b);
        return (b >= B_OP_ADD) && (b <= B_OP_DIV);
    endfunction

    function automatic op_t op_of(input active_button_t b);
        op_t o;
        case (b)
            B_OP_ADD: o = OP_ADD;
            B_OP_SUB: o = OP_SUB;
            B_OP_MUL: o = OP_MUL;
            B_OP_DIV: o = OP_DIV;
            default:  o = OP_NONE;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/calc_entry.sv
// Operand entry datapath: appends BCD digits left-aligned, toggles sign and
// clears the entry. Purely combinational; the caller owns the registers.
module calc_entry
    import calc_pkg::*;
#(
    parameter int DIGITS = 8,
    parameter int EXP_W  = $clog2(DIGITS)
) (
    input  logic [EXP_W+4*DIGITS:0] num_i,
    input  logic                    entry_active_i,
    input  entry_op_t               op_i,
    input  logic [3:0]              digit_i,
    output logic [EXP_W+4*DIGITS:0] num_o,
    output logic                    entry_active_o
);

    typedef struct packed {
        logic                   sign;
        logic [EXP_W-1:0]       exp;
        logic [DIGITS-1:0][3:0] sig;
    } dnum_t;

    dnum_t cur;
    dnum_t nxt;
    logic  sig_zero;

    assign cur      = num_i;
    assign num_o    = nxt;
    assign sig_zero = (cur.sig == '0);

    always_comb begin
        nxt            = cur;
        entry_active_o = entry_active_i;
        unique case (op_i)
            E_HOLD: begin
            end
            E_DIGIT: begin
                // A zero display restarts at the leading position, so leading
                // zeros never consume digit slots.
                if (!entry_active_i || sig_zero) begin
                    nxt                = '0;
                    nxt.sig[DIGITS-1]  = digit_i;
                    entry_active_o     = 1'b1;
                end else if (int'(cur.exp) < DIGITS - 1) begin
                    for (int i = 0; i < DIGITS; i++) begin
                        if (i == DIGITS - 2 - int'(cur.exp)) begin
                            nxt.sig[i] = digit_i;
                        end
                    end
                    nxt.exp = cur.exp + EXP_W'(1);
                end
            end
            E_NEG: begin
                if (!sig_zero) begin
                    nxt.sign = ~cur.sign;
                end
            end
            E_CLEAR: begin
                nxt            = '0;
                entry_active_o = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/calc_sequencer.sv
// Calculator sequencer: button handshake, operand entry, operator chaining,
// repeat-equals and a request/done handshake to a multi-cycle ALU.
//   state      | meaning
//   S_IDLE     | accepting buttons
//   S_ALU_REQ  | alu_valid_o high, operands held
//   S_ALU_WAIT | request taken, waiting for alu_done_i
//   S_ERROR    | sticky error, only B_CLEAR has effect
module calc_sequencer
    import calc_pkg::*;
#(
    parameter int DIGITS = 8,
    parameter int EXP_W  = $clog2(DIGITS)
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    button_valid_i,
    input  active_button_t          button_i,
    output logic                    button_ready_o,
    output logic                    alu_valid_o,
    input  logic                    alu_ready_i,
    output logic [EXP_W+4*DIGITS:0] alu_left_o,
    output logic [EXP_W+4*DIGITS:0] alu_right_o,
    output op_t                     alu_op_o,
    input  logic                    alu_done_i,
    input  logic [EXP_W+4*DIGITS:0] alu_result_i,
    input  logic                    alu_err_i,
    output logic [EXP_W+4*DIGITS:0] display_o,
    output logic [EXP_W+4*DIGITS:0] upper_o,
    output logic                    error_o
);

    localparam int NUM_W = EXP_W + 4 * DIGITS + 1;

    state_t           state_q, state_d;
    logic [NUM_W-1:0] display_q, display_d;
    logic [NUM_W-1:0] upper_q, upper_d;
    logic [NUM_W-1:0] last_operand_q, last_operand_d;
    logic [NUM_W-1:0] alu_left_q, alu_left_d;
    logic [NUM_W-1:0] alu_right_q, alu_right_d;
    op_t              pending_op_q, pending_op_d;
    op_t              last_op_q, last_op_d;
    op_t              alu_op_q, alu_op_d;
    logic             repeat_valid_q, repeat_valid_d;
    logic             entry_active_q, entry_active_d;
    logic             error_q, error_d;

    logic             accept;
    entry_op_t        entry_op;
    logic [3:0]       entry_digit;
    logic [NUM_W-1:0] entry_num;
    logic             entry_active_nxt;

    // Derived from the state flop so that reset drops them asynchronously.
    assign button_ready_o = (state_q == S_IDLE) || (state_q == S_ERROR);
    assign alu_valid_o    = (state_q == S_ALU_REQ);
    assign accept         = button_valid_i && button_ready_o;

    assign alu_left_o  = alu_left_q;
    assign alu_right_o = alu_right_q;
    assign alu_op_o    = alu_op_q;
    assign display_o   = display_q;
    assign upper_o     = upper_q;
    assign error_o     = error_q;

    always_comb begin
        entry_op    = E_HOLD;
        entry_digit = '0;
        if (accept && (state_q == S_IDLE)) begin
            if (is_digit(button_i)) begin
                entry_op    = E_DIGIT;
                entry_digit = digit_of(button_i);
            end else if (button_i == B_NEG) begin
                entry_op = E_NEG;
            end else if (button_i == B_CLEAR_ENTRY) begin
                entry_op = E_CLEAR;
            end
        end
    end

    calc_entry #(
        .DIGITS (DIGITS),
        .EXP_W  (EXP_W)
    ) u_entry (
        .num_i          (display_q),
        .entry_active_i (entry_active_q),
        .op_i           (entry_op),
        .digit_i        (entry_digit),
        .num_o          (entry_num),
        .entry_active_o (entry_active_nxt)
    );

    always_comb begin
        state_d        = state_q;
        display_d      = entry_num;
        entry_active_d = entry_active_nxt;
        upper_d        = upper_q;
        last_operand_d = last_operand_q;
        alu_left_d     = alu_left_q;
        alu_right_d    = alu_right_q;
        pending_op_d   = pending_op_q;
        last_op_d      = last_op_q;
        alu_op_d       = alu_op_q;
        repeat_valid_d = repeat_valid_q;
        error_d        = error_q;

        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (button_i == B_CLEAR) begin
                        display_d      = '0;
                        upper_d        = '0;
                        last_operand_d = '0;
                        alu_left_d     = '0;
                        alu_right_d    = '0;
                        pending_op_d   = OP_NONE;
                        last_op_d      = OP_NONE;
                        alu_op_d       = OP_NONE;
                        repeat_valid_d = 1'b0;
                        entry_active_d = 1'b0;
                        error_d        = 1'b0;
                    end else if (is_operator(button_i)) begin
                        if ((pending_op_q != OP_NONE) && entry_active_q) begin
                            alu_left_d  = upper_q;
                            alu_right_d = display_q;
                            alu_op_d    = pending_op_q;
                            state_d     = S_ALU_REQ;
                        end else begin
                            upper_d = display_q;
                        end
                        pending_op_d   = op_of(button_i);
                        entry_active_d = 1'b0;
                    end else if (button_i == B_OP_EQ) begin
                        if (pending_op_q != OP_NONE) begin
                            alu_left_d     = upper_q;
                            alu_right_d    = display_q;
                            alu_op_d       = pending_op_q;
                            last_op_d      = pending_op_q;
                            last_operand_d = display_q;
                            repeat_valid_d = 1'b1;
                            pending_op_d   = OP_NONE;
                            state_d        = S_ALU_REQ;
                        end else if (repeat_valid_q) begin
                            alu_left_d  = display_q;
                            alu_right_d = last_operand_q;
                            alu_op_d    = last_op_q;
                            state_d     = S_ALU_REQ;
                        end
                        entry_active_d = 1'b0;
                    end
                end
            end
            S_ALU_REQ, S_ALU_WAIT: begin
                // Done is honoured in REQ only together with the handshake.
                if (alu_done_i && ((state_q == S_ALU_WAIT) || alu_ready_i)) begin
                    if (alu_err_i) begin
                        error_d   = 1'b1;
                        display_d = '0;
                        state_d   = S_ERROR;
                    end else begin
                        display_d = alu_result_i;
                        upper_d   = alu_result_i;
                        state_d   = S_IDLE;
                    end
                end else if ((state_q == S_ALU_REQ) && alu_ready_i) begin
                    state_d = S_ALU_WAIT;
                end
            end
            S_ERROR: begin
                if (accept && (button_i == B_CLEAR)) begin
                    display_d      = '0;
                    upper_d        = '0;
                    last_operand_d = '0;
                    alu_left_d     = '0;
                    alu_right_d    = '0;
                    pending_op_d   = OP_NONE;
                    last_op_d      = OP_NONE;
                    alu_op_d       = OP_NONE;
                    repeat_valid_d = 1'b0;
                    entry_active_d = 1'b0;
                    error_d        = 1'b0;
                    state_d        = S_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q        <= S_IDLE;
            display_q      <= '0;
            upper_q        <= '0;
            last_operand_q <= '0;
            alu_left_q     <= '0;
            alu_right_q    <= '0;
            pending_op_q   <= OP_NONE;
            last_op_q      <= OP_NONE;
            alu_op_q       <= OP_NONE;
            repeat_valid_q <= 1'b0;
            entry_active_q <= 1'b0;
            error_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            display_q      <= display_d;
            upper_q        <= upper_d;
            last_operand_q <= last_operand_d;
            alu_left_q     <= alu_left_d;
            alu_right_q    <= alu_right_d;
            pending_op_q   <= pending_op_d;
            last_op_q      <= last_op_d;
            alu_op_q       <= alu_op_d;
            repeat_valid_q <= repeat_valid_d;
            entry_active_q <= entry_active_d;
            error_q        <= error_d;
        end
    end

endmodule

// File: tb/tb_calc_sequencer.sv
// Directed bench for calc_sequencer (DIGITS=8) with a scripted ALU responder.
module tb_calc_sequencer;
    import calc_pkg::*;

    logic           clk_i = 1'b0;
    logic           rst_ni;
    logic           button_valid_i;
    active_button_t button_i;
    logic           button_ready_o;
    logic           alu_valid_o;
    logic           alu_ready_i;
    num_t           alu_left_o;
    num_t           alu_right_o;
    op_t            alu_op_o;
    logic           alu_done_i;
    num_t           alu_result_i;
    logic           alu_err_i;
    num_t           display_o;
    num_t           upper_o;
    logic           error_o;

    int n_tests = 0;
    int n_fail  = 0;

    calc_sequencer #(.DIGITS(8)) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .button_valid_i (button_valid_i),
        .button_i       (button_i),
        .button_ready_o (button_ready_o),
        .alu_valid_o    (alu_valid_o),
        .alu_ready_i    (alu_ready_i),
        .alu_left_o     (alu_left_o),
        .alu_right_o    (alu_right_o),
        .alu_op_o       (alu_op_o),
        .alu_done_i     (alu_done_i),
        .alu_result_i   (alu_result_i),
        .alu_err_i      (alu_err_i),
        .display_o      (display_o),
        .upper_o        (upper_o),
        .error_o        (error_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic num_t mk(input int v);
        num_t n;
        int   digs[8];
        int   nd;
        int   t;
        n  = '0;
        nd = 0;
        t  = v;
        for (int k = 0; k < 8; k++) digs[k] = 0;
        if (v == 0) return n;
        while (t > 0 && nd < 8) begin
            digs[nd] = t % 10;
            t        = t / 10;
            nd++;
        end
        for (int i = 0; i < nd; i++) n.sig[7-i] = 4'(digs[nd-1-i]);
        n.exp = 3'(nd - 1);
        return n;
    endfunction

    task automatic press(input active_button_t b);
        int n;
        n = 0;
        while (!button_ready_o && n < 50) begin
            @(negedge clk_i);
            n++;
        end
        if (n == 50) chk("ready_timeout", {63'd0, button_ready_o}, 64'd1);
        button_valid_i = 1'b1;
        button_i       = b;
        @(posedge clk_i);
        #1;
        button_valid_i = 1'b0;
        button_i       = B_NONE;
    endtask

    // Call right after press() of the request-issuing button; done is driven
    // two cycles after the request appears.
    task automatic alu_serve(input string tag, input num_t l, input op_t o, input num_t r,
                             input num_t res, input logic err, output int low);
        low = 0;
        chk({tag, "_valid"}, {63'd0, alu_valid_o}, 64'd1);
        chk({tag, "_left"},  alu_left_o,  l);
        chk({tag, "_right"}, alu_right_o, r);
        chk({tag, "_op"},    alu_op_o,    o);
        if (!button_ready_o) low++;
        @(posedge clk_i); #1;
        if (!button_ready_o) low++;
        @(posedge clk_i); #1;
        if (!button_ready_o) low++;
        alu_done_i   = 1'b1;
        alu_result_i = res;
        alu_err_i    = err;
        @(posedge clk_i); #1;
        alu_done_i   = 1'b0;
        alu_err_i    = 1'b0;
        alu_result_i = '0;
        if (!button_ready_o) low++;
    endtask

    initial begin
        int   low;
        num_t d;
        num_t neg5;

        rst_ni         = 1'b0;
        button_valid_i = 1'b0;
        button_i       = B_NONE;
        alu_ready_i    = 1'b1;
        alu_done_i     = 1'b0;
        alu_result_i   = '0;
        alu_err_i      = 1'b0;
        repeat (3) @(negedge clk_i);

        chk("rst_display", display_o, 64'd0);
        chk("rst_upper",   upper_o,   64'd0);
        chk("rst_error",   {63'd0, error_o},        64'd0);
        chk("rst_valid",   {63'd0, alu_valid_o},    64'd0);
        chk("rst_ready",   {63'd0, button_ready_o}, 64'd1);
        chk("rst_left",    alu_left_o,  64'd0);
        chk("rst_op",      alu_op_o,    OP_NONE);
        rst_ni = 1'b1;
        @(negedge clk_i);

        press(B_NUM_1);
        chk("digit_1", display_o, mk(1));
        press(B_NUM_2);
        press(B_NUM_3);
        chk("digit_123", display_o, mk(123));
        d = display_o;
        chk("digit_123_exp", d.exp, 64'd2);

        press(B_CLEAR);
        press(B_NUM_1); press(B_NUM_2); press(B_NUM_3);
        press(B_NUM_4); press(B_NUM_5); press(B_NUM_6);
        press(B_NUM_7); press(B_NUM_8); press(B_NUM_9);
        chk("nine_digits", display_o, mk(12345678));
        d = display_o;
        chk("nine_digits_exp", d.exp, 64'd7);

        press(B_CLEAR);
        chk("clear_display", display_o, 64'd0);
        press(B_NUM_1);
        press(B_OP_ADD);
        chk("op_no_request", {63'd0, alu_valid_o}, 64'd0);
        chk("op_upper", upper_o, mk(1));
        press(B_NUM_2);
        press(B_OP_EQ);
        alu_serve("add", mk(1), OP_ADD, mk(2), mk(3), 1'b0, low);
        chk("add_ready_low", low, 64'd3);
        chk("add_display", display_o, mk(3));
        chk("add_upper",   upper_o,   mk(3));

        press(B_OP_EQ);
        alu_serve("rep1", mk(3), OP_ADD, mk(2), mk(5), 1'b0, low);
        chk("rep1_display", display_o, mk(5));
        press(B_OP_EQ);
        alu_serve("rep2", mk(5), OP_ADD, mk(2), mk(7), 1'b0, low);
        chk("rep2_display", display_o, mk(7));

        press(B_CLEAR);
        press(B_NUM_2);
        press(B_OP_MUL);
        press(B_NUM_3);
        press(B_OP_ADD);
        alu_serve("chain_mul", mk(2), OP_MUL, mk(3), mk(6), 1'b0, low);
        chk("chain_mul_display", display_o, mk(6));
        press(B_NUM_4);
        press(B_OP_EQ);
        alu_serve("chain_add", mk(6), OP_ADD, mk(4), mk(10), 1'b0, low);
        chk("chain_display", display_o, mk(10));
        chk("chain_upper",   upper_o,   mk(10));

        press(B_CLEAR);
        press(B_NUM_5);
        press(B_NEG);
        neg5      = mk(5);
        neg5.sign = 1'b1;
        chk("neg_display", display_o, neg5);
        press(B_CLEAR_ENTRY);
        chk("ce_display", display_o, 64'd0);
        press(B_NEG);
        chk("neg_zero", display_o, 64'd0);
        press(B_NUM_0);
        press(B_NUM_0);
        press(B_NUM_7);
        chk("leading_zero", display_o, mk(7));

        press(B_CLEAR);
        press(B_NUM_5);
        press(B_OP_DIV);
        press(B_NUM_0);
        press(B_OP_EQ);
        alu_serve("div0", mk(5), OP_DIV, mk(0), mk(0), 1'b1, low);
        chk("div0_error",   {63'd0, error_o}, 64'd1);
        chk("div0_display", display_o, 64'd0);
        press(B_NUM_7);
        chk("err_digit_ignored", display_o, 64'd0);
        press(B_CLEAR);
        chk("err_clear_error",   {63'd0, error_o}, 64'd0);
        chk("err_clear_display", display_o, 64'd0);

        press(B_NUM_1);
        press(B_OP_ADD);
        press(B_NUM_2);
        press(B_OP_EQ);
        chk("mid_req_valid", {63'd0, alu_valid_o}, 64'd1);
        @(posedge clk_i); #1;
        chk("mid_wait_valid", {63'd0, alu_valid_o}, 64'd0);
        chk("mid_wait_ready", {63'd0, button_ready_o}, 64'd0);
        rst_ni = 1'b0;
        #1;
        chk("mid_rst_valid",   {63'd0, alu_valid_o},    64'd0);
        chk("mid_rst_ready",   {63'd0, button_ready_o}, 64'd1);
        chk("mid_rst_display", display_o,  64'd0);
        chk("mid_rst_upper",   upper_o,    64'd0);
        chk("mid_rst_left",    alu_left_o, 64'd0);
        @(negedge clk_i);
        rst_ni       = 1'b1;
        alu_done_i   = 1'b1;
        alu_result_i = mk(3);
        @(posedge clk_i); #1;
        alu_done_i   = 1'b0;
        alu_result_i = '0;
        chk("late_done_display", display_o, 64'd0);
        chk("late_done_error",   {63'd0, error_o}, 64'd0);
        press(B_OP_EQ);
        chk("post_rst_no_repeat", {63'd0, alu_valid_o}, 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
